acc_fwd_sched: RTL

Controller placed in front of the softmax group-accumulation/forwarding stage, which is a 12-stage enable-gated pipeline. It accepts a chunk stream with a valid/ready handshake and makes sure each multi-chunk group enters the accumulator as back-to-back valid beats under one length mode. It converts downstream backpressure into a pipeline-wide enable and tracks beats in flight. It also provides a flush/idle handshake and sticky protocol-error flags.

---
 rtl/acc_fwd_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/acc_fwd_sched.sv
// Issue controller for the softmax group-accumulation/forwarding pipeline.
// It keeps each multi-chunk group contiguous in enabled cycles under one
// length mode. It turns up/downstream stalls into a pipeline-wide enable,
// counts beats in flight, and implements the flush/idle handshake and
// sticky protocol-error flags.
module acc_fwd_sched #(
    parameter int DEPTH     = 12,
    parameter int STALL_MAX = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    input  logic [3:0] i_s_mode,
    output logic       o_acc_en,
    output logic       o_acc_valid_sum,
    output logic [3:0] o_acc_length_mode,
    input  logic       i_acc_out_valid,
    output logic       o_m_valid,
    input  logic       i_m_ready,
    input  logic       i_flush,
    output logic       o_idle,
    output logic [4:0] o_inflight,
    output logic [2:0] o_err
);

    localparam int                STALL_W      = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM    = STALL_W'(STALL_MAX);
    localparam logic [4:0]        INFLIGHT_MAX = 5'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        GROUP = 1'b1
    } state_e;

    state_e               state_q;
    logic [3:0]           mode_q;
    logic [3:0]           rem_q;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [4:0]           inflight_q, inflight_d;
    logic [2:0]           err_q, err_d;

    logic in_group, stall_up, stall_dn, issue, drain, mode_illegal;

    // Modes 14 and 15 are not defined; they are accepted as single beats.
    function automatic logic is_illegal(input logic [3:0] m);
        return m >= 4'd14;
    endfunction

    // Number of chunks that make up one group of the given length mode.
    function automatic logic [3:0] mode_beats(input logic [3:0] m);
        if (m <= 4'd2 || m >= 4'd14) begin
            return 4'd1;
        end
        return m - 4'd1;
    endfunction

    assign in_group     = (state_q == GROUP);
    assign mode_illegal = is_illegal(i_s_mode);

    // Starving a group freezes the whole pipeline so the accumulator never sees
    // a hole inside a group; a held output beat freezes it too.
    assign stall_up = in_group & ~i_s_valid;
    assign stall_dn = i_acc_out_valid & ~i_m_ready;

    assign o_acc_en        = ~stall_up & ~stall_dn;
    assign o_m_valid       = i_acc_out_valid & ~stall_up;
    assign o_s_ready       = o_acc_en & ~(~in_group & i_flush);
    assign issue           = i_s_valid & o_s_ready;
    assign drain           = o_m_valid & i_m_ready;
    assign o_acc_valid_sum = issue;

    // Inside a group the latched mode is authoritative, even if a chunk disagrees.
    assign o_acc_length_mode = in_group ? mode_q : (mode_illegal ? 4'd0 : i_s_mode);

    assign o_inflight = inflight_q;
    assign o_err      = err_q;
    assign o_idle     = ~in_group & (inflight_q == 5'd0);

    // Next values of the stall counter, in-flight counter and error flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        stall_d    = stall_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        if (issue) begin
            stall_d = '0;
        end else if (stall_up && stall_q != STALL_LIM) begin
            stall_d = stall_q + 1'b1;
        end

        if (issue && !drain && inflight_q != INFLIGHT_MAX) begin
            inflight_d = inflight_q + 5'd1;
        end else if (drain && !issue && inflight_q != 5'd0) begin
            inflight_d = inflight_q - 5'd1;
        end

        if (issue && in_group && i_s_mode != mode_q) begin
            err_d[0] = 1'b1;
        end
        if (issue && mode_illegal) begin
            err_d[1] = 1'b1;
        end
        if (stall_up && stall_d == STALL_LIM) begin
            err_d[2] = 1'b1;
        end
    end

    // Group FSM: opens on the first beat of a multi-beat mode, closes on its last.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
        end else if (issue) begin
            case (state_q)
                IDLE: begin
                    if (mode_beats(i_s_mode) != 4'd1) begin
                        mode_q  <= i_s_mode;
                        rem_q   <= mode_beats(i_s_mode) - 4'd1;
                        state_q <= GROUP;
                    end
                end
                GROUP: begin
                    if (rem_q == 4'd1) begin
                        rem_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q    <= '0;
            inflight_q <= '0;
            err_q      <= '0;
        end else begin
            stall_q    <= stall_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

endmodule
